// File: rtl/bcd_seg_scan_if.sv
// Bus bundle between a BCD producer and the bcd_seg_scan display driver.
// The producer side uses the master modport; the scanner uses the slave modport.
interface bcd_seg_scan_if #(
  parameter int NUM_DIGITS = 2
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    ack;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic [2:0]              digit_ix;

  modport master (output load, bcd_in, input ack, seg, an, digit_ix);
  modport slave  (input load, bcd_in, output ack, seg, an, digit_ix);
endinterface

// File: rtl/bcd_seg_scan.sv
// Latches packed BCD digits and scans them onto a common-anode 7-segment display.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_BLANK_EN.
module bcd_seg_scan #(
  parameter int NUM_DIGITS  = 2,
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  bcd_seg_scan_if.slave bus
);
  localparam logic [0:0] S_GAP  = 1'b0;
  localparam logic [0:0] S_SHOW = 1'b1;

  localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [2:0]       IX_LAST   = 3'(NUM_DIGITS - 1);

  logic [0:0]              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [2:0]              r_ix;
  logic                    r_first;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_ack;

  logic [0:0]              w_state_next;
  logic [CNT_W-1:0]        w_cnt_next;
  logic [2:0]              w_ix_next;
  logic [2:0]              w_ix_adv;
  logic                    w_first_next;
  logic [4*NUM_DIGITS-1:0] w_shadow_next;
  logic [3:0]              w_digit [0:7];
  logic                    w_blank;
  logic [6:0]              w_seg_next;
  logic [NUM_DIGITS-1:0]   w_an_next;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    f_decode = 7'h40;
      4'd1:    f_decode = 7'h79;
      4'd2:    f_decode = 7'h24;
      4'd3:    f_decode = 7'h30;
      4'd4:    f_decode = 7'h19;
      4'd5:    f_decode = 7'h12;
      4'd6:    f_decode = 7'h02;
      4'd7:    f_decode = 7'h78;
      4'd8:    f_decode = 7'h00;
      4'd9:    f_decode = 7'h10;
      default: f_decode = 7'h3F;
    endcase
  endfunction

  // Outputs are decoded from next-cycle values so a load on an advance edge shows at once.
  assign w_shadow_next = bus.load ? bus.bcd_in : r_shadow;
  assign w_ix_adv      = (r_ix == IX_LAST) ? 3'd0 : r_ix + 3'd1;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CNT_W'(1);
    w_ix_next    = r_ix;
    w_first_next = r_first;
    if (r_state == S_SHOW) begin
      if (r_cnt == SHOW_LAST) begin
        w_cnt_next = '0;
        if (GAP_CYCLES == 0) w_ix_next = w_ix_adv;
        else                 w_state_next = S_GAP;
      end
    end else begin
      // The gap that follows reset enters digit 0 without advancing.
      if ((GAP_CYCLES == 0) || (r_cnt == GAP_LAST)) begin
        w_cnt_next   = '0;
        w_state_next = S_SHOW;
        w_first_next = 1'b0;
        if (!r_first) w_ix_next = w_ix_adv;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      if (gi < NUM_DIGITS) begin : g_used
        assign w_digit[gi] = w_shadow_next[4*gi +: 4];
      end else begin : g_pad
        assign w_digit[gi] = 4'd0;
      end
    end
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
      assign w_an_next[gi] = !((w_state_next == S_SHOW) && (w_ix_next == 3'(gi)));
    end
  endgenerate

`ifdef BCD_SCAN_BLANK_EN
  logic w_lead;
  always_comb begin
    w_lead  = 1'b1;
    w_blank = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      w_lead = w_lead && (w_digit[i] == 4'd0);
      if ((3'(i) == w_ix_next) && (i != 0)) w_blank = w_lead;
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  assign w_seg_next = ((w_state_next == S_SHOW) && !w_blank) ? f_decode(w_digit[w_ix_next])
                                                              : 7'h7F;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_GAP;
      r_cnt    <= '0;
      r_ix     <= 3'd0;
      r_first  <= 1'b1;
      r_shadow <= '0;
      r_seg    <= 7'h7F;
      r_an     <= '1;
      r_ack    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_ix     <= w_ix_next;
      r_first  <= w_first_next;
      r_shadow <= w_shadow_next;
      r_seg    <= w_seg_next;
      r_an     <= w_an_next;
      r_ack    <= bus.load;
    end
  end

  assign bus.seg      = r_seg;
  assign bus.an       = r_an;
  assign bus.ack      = r_ack;
  assign bus.digit_ix = r_ix;
endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan (2 digits, dwell 4, gap 1) with an expectation queue.
// Build with BCD_SCAN_BLANK_EN defined to check leading-zero blanking.
module tb_bcd_seg_scan;
  logic clk;
  logic rst_n;

  bcd_seg_scan_if #(.NUM_DIGITS(2)) bus();

  bcd_seg_scan #(
    .NUM_DIGITS (2),
    .REFRESH_DIV(4),
    .GAP_CYCLES (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [1:0] an;
    logic [6:0] seg;
    logic       ack;
    logic [2:0] ix;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

`ifdef BCD_SCAN_BLANK_EN
  localparam logic [6:0] LEAD0 = 7'h7F;
`else
  localparam logic [6:0] LEAD0 = 7'h40;
`endif

  task automatic check_now(input string tag, input logic [1:0] an_e,
                           input logic [6:0] seg_e, input logic ack_e);
    n_vec++;
    assert (bus.an === an_e) else begin
      n_miss++;
      $error("FAIL %s an got %b want %b", tag, bus.an, an_e);
    end
    n_vec++;
    assert (bus.seg === seg_e) else begin
      n_miss++;
      $error("FAIL %s seg got %h want %h", tag, bus.seg, seg_e);
    end
    n_vec++;
    assert (bus.ack === ack_e) else begin
      n_miss++;
      $error("FAIL %s ack got %b want %b", tag, bus.ack, ack_e);
    end
  endtask

  // Push the expected outputs, clock once, then pop and compare.
  task automatic cyc(input string tag, input logic [1:0] an_e, input logic [6:0] seg_e,
                     input logic ack_e, input logic [2:0] ix_e);
    exp_t e;
    e.tag = tag; e.an = an_e; e.seg = seg_e; e.ack = ack_e; e.ix = ix_e;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check_now(e.tag, e.an, e.seg, e.ack);
    if (e.an != 2'b11) begin
      n_vec++;
      assert (bus.digit_ix === e.ix) else begin
        n_miss++;
        $error("FAIL %s digit_ix got %0d want %0d", e.tag, bus.digit_ix, e.ix);
      end
    end
    $display("t=%0t %s an=%b seg=%h ack=%b ix=%0d", $time, e.tag, bus.an, bus.seg,
             bus.ack, bus.digit_ix);
  endtask

  task automatic show(input string tag, input int n, input logic [2:0] d,
                      input logic [6:0] seg_e);
    for (int k = 0; k < n; k++)
      cyc(tag, (d == 3'd0) ? 2'b10 : 2'b01, seg_e, 1'b0, d);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.load   = 1'b0;
    bus.bcd_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_now("reset_held", 2'b11, 7'h7F, 1'b0);
    rst_n = 1'b1;
    #1;
    check_now("reset_release", 2'b11, 7'h7F, 1'b0);

    cyc("first_show_d0", 2'b10, 7'h40, 1'b0, 3'd0);
    bus.load = 1'b1; bus.bcd_in = 8'h19;
    cyc("load19_ack", 2'b10, 7'h10, 1'b1, 3'd0);
    bus.load = 1'b0;
    cyc("ack_drop", 2'b10, 7'h10, 1'b0, 3'd0);
    cyc("d0_last", 2'b10, 7'h10, 1'b0, 3'd0);
    cyc("gap_a", 2'b11, 7'h7F, 1'b0, 3'd0);
    show("d1_19", 4, 3'd1, 7'h79);
    cyc("gap_b", 2'b11, 7'h7F, 1'b0, 3'd0);

    for (int f = 0; f < 2; f++) begin
      show("frame_d0", 4, 3'd0, 7'h10);
      cyc("frame_gap0", 2'b11, 7'h7F, 1'b0, 3'd0);
      show("frame_d1", 4, 3'd1, 7'h79);
      cyc("frame_gap1", 2'b11, 7'h7F, 1'b0, 3'd0);
    end

    bus.load = 1'b1; bus.bcd_in = 8'h0C;
    cyc("load0C_dash", 2'b10, 7'h3F, 1'b1, 3'd0);
    bus.load = 1'b0;
    show("d0_dash", 3, 3'd0, 7'h3F);
    cyc("gap_c", 2'b11, 7'h7F, 1'b0, 3'd0);
    show("d1_lead0", 4, 3'd1, LEAD0);
    cyc("gap_d", 2'b11, 7'h7F, 1'b0, 3'd0);
    show("d0_dash2", 4, 3'd0, 7'h3F);
    cyc("gap_e", 2'b11, 7'h7F, 1'b0, 3'd0);

    bus.load = 1'b1; bus.bcd_in = 8'h25;
    cyc("load25_on_adv", 2'b01, 7'h24, 1'b1, 3'd1);
    bus.load = 1'b0;
    show("d1_25", 3, 3'd1, 7'h24);
    cyc("gap_f", 2'b11, 7'h7F, 1'b0, 3'd0);
    cyc("d0_25", 2'b10, 7'h12, 1'b0, 3'd0);

    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", 2'b11, 7'h7F, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    show("restart_d0", 4, 3'd0, 7'h40);
    cyc("restart_gap", 2'b11, 7'h7F, 1'b0, 3'd0);
    show("restart_d1", 4, 3'd1, LEAD0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
